// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_sched_pkg
// Description : Shared types for fifo_port_sched: read-sequencer state
//               encoding and bit positions inside the sticky error vector.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sched_pkg;

  // Read sequencer: wait for enough data, issue a burst, then one idle cycle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } rd_state_t;

  // Positions inside the sticky err vector
  localparam int ERR_OVF = 0;  // fifo_mem reported overflow
  localparam int ERR_UNF = 1;  // fifo_mem reported underflow
  localparam int ERR_MIS = 2;  // fifo_mem full/empty disagrees with our level

endpackage : fifo_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with one grant per cycle. The search
//               starts at the requester after the last one granted; the
//               pointer only moves when a grant is actually issued.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Pointer starts at the last requester so requester 0 wins first
  localparam logic [PW-1:0] C_LAST_INIT = PW'(NREQ - 1);

  logic [PW-1:0] r_last;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_idx;
  logic          w_found;

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v % NREQ);
  endfunction

  // Priority search beginning one past the last granted requester
  always_comb begin
    gnt     = '0;
    w_sel   = r_last;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = wrap_idx(int'(r_last) + k);
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_sel      = w_idx;
        w_found    = 1'b1;
      end
    end
  end

  // Remember who was served so they drop to lowest priority next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= C_LAST_INIT;
    end else if (w_found) begin
      r_last <= w_sel;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fifo_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : fifo_port_sched
// Description : Front-end for fifo_mem. Shares the single write port among
//               NREQ producers (round-robin), drains in fixed-length read
//               bursts, tracks occupancy so writes never overflow, and
//               cross-checks that occupancy against the fifo_mem flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_port_sched
  import fifo_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  parameter  int BURST = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_data_in,
  output logic               fifo_rd,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  input  logic               fifo_threshold,
  input  logic               fifo_overflow,
  input  logic               fifo_underflow,
  input  logic               drain_ready,
  input  logic               flush,
  output logic               rd_valid,
  output logic [CW-1:0]      level,
  output logic [2:0]         err,
  input  logic               err_clr
);

  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [CW-1:0] C_BURST     = CW'(BURST);
  localparam logic [CW-1:0] C_BEAT_LAST = CW'(BURST - 1);

  rd_state_t     r_state;
  logic [CW-1:0] r_beat;
  logic [CW-1:0] r_level;
  logic [CW-1:0] r_level_d1;
  logic          r_wr;
  logic [DW-1:0] r_wdata;
  logic          r_rd;
  logic          r_rd_valid;
  logic [2:0]    r_err;

  logic          w_arb_en;
  logic          w_wr_next;
  logic          w_rd_next;
  logic [DW-1:0] w_wdata;
  logic [CW-1:0] w_level_next;
  logic          w_mis;
  logic [2:0]    w_err_evt;
  // Threshold is informational only; it never gates the sequencer
  logic          w_unused;

  assign w_unused = fifo_threshold;

  // Grants are held off during reset and whenever the FIFO is (or will be) full
  assign w_arb_en = rst_n && (r_level < C_DEPTH);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (w_arb_en),
    .gnt   (gnt)
  );

  assign w_wr_next = |gnt;

  // Select the granted producer's word (gnt is one-hot)
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        w_wdata = req_data[i*DW +: DW];
      end
    end
  end

  // A read is issued only inside a burst, with a willing consumer and data present
  always_comb begin
    w_rd_next = (r_state == ST_BURST) && drain_ready && (r_level != '0);
  end

  // Occupancy includes strobes registered this edge; reads do not free space early
  assign w_level_next = r_level + CW'(w_wr_next) - CW'(w_rd_next);

  // Write-port registers and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_level    <= '0;
      r_level_d1 <= '0;
    end else begin
      r_wr       <= w_wr_next;
      if (w_wr_next) begin
        r_wdata <= w_wdata;
      end
      r_level    <= w_level_next;
      r_level_d1 <= r_level;
    end
  end

  // Read sequencer: IDLE -> BURST -> GAP -> IDLE, with registered read strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_rd       <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd       <= w_rd_next;
      r_rd_valid <= r_rd;
      case (r_state)
        ST_IDLE: begin
          if (drain_ready && ((r_level >= C_BURST) || (flush && (r_level != '0)))) begin
            r_state <= ST_BURST;
            r_beat  <= '0;
          end
        end
        ST_BURST: begin
          if (w_rd_next) begin
            r_beat <= r_beat + CW'(1);
          end
          // Finish on the last beat, or early once the FIFO runs dry
          if ((w_rd_next && (r_beat == C_BEAT_LAST)) || (w_level_next == '0)) begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // fifo_mem flags lag our level by one cycle, so compare against the delayed copy
  assign w_mis = (fifo_full  != (r_level_d1 == C_DEPTH)) ||
                 (fifo_empty != (r_level_d1 == '0));

  always_comb begin
    w_err_evt          = '0;
    w_err_evt[ERR_OVF] = fifo_overflow;
    w_err_evt[ERR_UNF] = fifo_underflow;
    w_err_evt[ERR_MIS] = w_mis;
  end

  // Sticky error capture; a fresh event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= (err_clr ? 3'b000 : r_err) | w_err_evt;
    end
  end

  assign fifo_wr      = r_wr;
  assign fifo_data_in = r_wdata;
  assign fifo_rd      = r_rd;
  assign rd_valid     = r_rd_valid;
  assign level        = r_level;
  assign err          = r_err;

endmodule : fifo_port_sched
`default_nettype wire

// File: tb/tb_fifo_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_port_sched
// Description : Directed self-checking bench for fifo_port_sched with a small
//               behavioural fifo_mem occupancy model driving the status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_port_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_wr;
  logic [7:0]  fifo_data_in;
  logic        fifo_rd;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_threshold;
  logic        fifo_overflow;
  logic        fifo_underflow;
  logic        drain_ready;
  logic        flush;
  logic        rd_valid;
  logic [4:0]  level;
  logic [2:0]  err;
  logic        err_clr;
  logic        force_full;

  int n_checks;
  int n_errors;
  int m_cnt;

  fifo_port_sched #(
    .NREQ  (4),
    .DW    (8),
    .DEPTH (16),
    .BURST (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .fifo_wr        (fifo_wr),
    .fifo_data_in   (fifo_data_in),
    .fifo_rd        (fifo_rd),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_threshold (fifo_threshold),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .drain_ready    (drain_ready),
    .flush          (flush),
    .rd_valid       (rd_valid),
    .level          (level),
    .err            (err),
    .err_clr        (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // fifo_mem occupancy model: acts on the strobes it samples
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 0;
    else        m_cnt <= m_cnt + int'(fifo_wr) - int'(fifo_rd);
  end

  assign fifo_full      = force_full || (m_cnt == 16);
  assign fifo_empty     = (m_cnt == 0);
  assign fifo_threshold = (m_cnt >= 8);
  assign fifo_overflow  = fifo_wr && (m_cnt == 16);
  assign fifo_underflow = fifo_rd && (m_cnt == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fill(input int n);
    req = 4'b0001;
    repeat (n) tick();
    req = 4'b0000;
    #1;
  endtask

  // Observe n cycles of the read side and summarise the strobe pattern
  task automatic trace(input int n, output int nrd, output int runs, output int maxrun,
                       output int vmis, output int zrd);
    logic prev_rd;
    int   cur;
    nrd = 0; runs = 0; maxrun = 0; vmis = 0; zrd = 0; cur = 0;
    prev_rd = fifo_rd;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rd_valid !== prev_rd) vmis++;
      if (fifo_rd) begin
        nrd++;
        if (m_cnt == 0) zrd++;
        if (!prev_rd) runs++;
        cur++;
        if (cur > maxrun) maxrun = cur;
      end else begin
        cur = 0;
      end
      prev_rd = fifo_rd;
    end
  endtask

  initial begin
    int nwr, nrd, runs, maxrun, vmis, zrd, pr;
    logic found;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    req         = 4'hF;
    req_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    drain_ready = 1'b0;
    flush       = 1'b0;
    err_clr     = 1'b0;
    force_full  = 1'b0;

    // Reset with every producer requesting
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr", 32'(fifo_wr), 32'h0);
    check("rst_rd", 32'(fifo_rd), 32'h0);
    check("rst_rdv", 32'(rd_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_gnt", 32'(gnt), 32'h1);
    check("rel_level", 32'(level), 32'h0);

    // Round-robin across all four producers, no draining
    for (int k = 0; k < 8; k++) begin
      check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      tick();
      check("rr_wr", 32'(fifo_wr), 32'h1);
      check("rr_data", 32'(fifo_data_in), 32'(8'hA0 + k % 4));
    end
    req = 4'b0000;
    #1;
    check("rr_level", 32'(level), 32'd8);
    tick();
    check("idle_wr", 32'(fifo_wr), 32'h0);
    check("idle_data_hold", 32'(fifo_data_in), 32'hA3);

    // Reset mid-operation, then fill from a single producer
    rst_n = 1'b0;
    #1;
    check("midrst_level", 32'(level), 32'h0);
    check("midrst_wr", 32'(fifo_wr), 32'h0);
    #2;
    rst_n = 1'b1;
    req   = 4'b0001;
    nwr   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo_wr) nwr++;
    end
    check("fill_gnt", 32'(gnt), 32'h0);
    check("fill_nwr", 32'(nwr), 32'd16);
    check("fill_level", 32'(level), 32'd16);
    req = 4'b0000;
    tick();
    check("fill_full", 32'(fifo_full), 32'h1);
    check("fill_err", 32'(err), 32'h0);

    // Two full bursts from level 10
    do_reset();
    fill(10);
    check("b_level0", 32'(level), 32'd10);
    drain_ready = 1'b1;
    trace(30, nrd, runs, maxrun, vmis, zrd);
    drain_ready = 1'b0;
    check("b_nrd", 32'(nrd), 32'd8);
    check("b_runs", 32'(runs), 32'd2);
    check("b_maxrun", 32'(maxrun), 32'd4);
    check("b_rdvalid", 32'(vmis), 32'd0);
    check("b_level", 32'(level), 32'd2);

    // Short flush burst from level 3
    fill(1);
    check("f_level0", 32'(level), 32'd3);
    flush       = 1'b1;
    drain_ready = 1'b1;
    trace(15, nrd, runs, maxrun, vmis, zrd);
    flush       = 1'b0;
    drain_ready = 1'b0;
    check("f_nrd", 32'(nrd), 32'd3);
    check("f_runs", 32'(runs), 32'd1);
    check("f_rd_at_zero", 32'(zrd), 32'd0);
    check("f_level", 32'(level), 32'd0);
    tick();
    check("f_empty", 32'(fifo_empty), 32'h1);
    check("f_err", 32'(err), 32'h0);

    // Flag mismatch detection and clear, at level 5
    fill(5);
    tick();
    tick();
    check("m_level", 32'(level), 32'd5);
    force_full = 1'b1;
    tick();
    force_full = 1'b0;
    check("m_err", 32'(err), 32'h4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("m_clr", 32'(err), 32'h0);

    // Burst paused by drain_ready dropping, then resumed
    drain_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_rd) begin
        found = 1'b1;
        break;
      end
    end
    check("p_start", 32'(found), 32'h1);
    nrd = 1;
    drain_ready = 1'b0;
    pr = 0;
    repeat (2) begin
      tick();
      pr += int'(fifo_rd);
    end
    check("p_paused", 32'(pr), 32'd0);
    drain_ready = 1'b1;
    repeat (12) begin
      tick();
      nrd += int'(fifo_rd);
    end
    drain_ready = 1'b0;
    check("p_nrd", 32'(nrd), 32'd4);
    check("p_level", 32'(level), 32'd1);
    check("p_err", 32'(err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fifo_port_sched
`default_nettype wire
